icache_refill_controller: RTL
=============================

Name: icache_refill_controller

Overview:
- Parametrised next-generation instruction-cache miss controller. Sits between the fetch stage, the I-cache data/tag array and main memory.
- Refills a missing block over a multi-beat memory interface and returns the addressed word to the pipeline.
- Optional next-line prefetch fills a one-entry stream buffer. A later miss that matches the buffer refills the cache without a memory access.

Parameters:
ADDR_SIZE, 32, byte address width
WORD_BITS, 32, instruction word width; byte-addressed, WORD_BITS/8 bytes per word
BLOCK_WORDS, 4, words per cache block; power of 2, >=2
BEAT_WORDS, 1, words per memory beat; power of 2, divides BLOCK_WORDS
PREFETCH_EN, 1, 1 = next-line prefetch into the stream buffer; 0 = buffer never valid
Derived values:
- BLOCK_BITS = BLOCK_WORDS*WORD_BITS
- BEATS = BLOCK_WORDS/BEAT_WORDS
- OFF = log2(BLOCK_WORDS*WORD_BITS/8)
- BADDR = ADDR_SIZE-OFF

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
ren  in  1  pipeline fetch request
addr  in  ADDR_SIZE  fetch byte address
stall  out  1  pipeline stall
dout  out  WORD_BITS  fetched word
lookupBlockAddr  out  BADDR  = addr[ADDR_SIZE-1:OFF], cache lookup index/tag (combinational)
cacheRen  out  1  = ren && !reset
cacheHit  in  1  lookup hit for lookupBlockAddr, same cycle
cacheDout  in  BLOCK_BITS  block read for lookupBlockAddr
cacheMemWen  out  1  cache block write strobe
fillBlockAddr  out  BADDR  block address for the cache write and the memory request
cacheDin  out  BLOCK_BITS  block to write; zero when cacheMemWen=0
memRen  out  1  memory read request, held until acknowledged
memReqAck  in  1  memory accepted the request
memBeatValid  in  1  one beat valid this cycle
memBeatData  in  BEAT_WORDS*WORD_BITS  beat payload, ascending word order

Behaviour:
- Reset (async, any state):
  - state=IDLE; beat counter=0; fill register=0; stream-buffer valid=0.
  - stall, cacheMemWen and memRen are 0; cacheDin is 0.
  - An in-flight memory transaction is abandoned. Beats still arriving afterwards are ignored.
- dout: word addr[OFF-1:log2(WORD_BITS/8)] of cacheDout. Valid whenever stall=0 and ren=1.
- miss = ren && !cacheHit.
- States: IDLE, DREQ, DBEAT, DWRITE, PREQ, PBEAT.
- IDLE:
  - stall=miss.
  - On a miss that matches the stream buffer (pbValid && pbTag==lookupBlockAddr): load the fill register from the buffer, clear pbValid, go to DWRITE.
  - On any other miss: latch fillBlockAddr=lookupBlockAddr and go to DREQ.
- DREQ: stall=1, memRen=1. On memReqAck go to DBEAT with counter=0. Beats arriving in DREQ are ignored.
- DBEAT:
  - stall=1.
  - Each memBeatValid writes beat k into fill register bits [k*BEAT_WORDS*WORD_BITS +: BEAT_WORDS*WORD_BITS] and increments k.
  - On beat BEATS-1 go to DWRITE. Gaps between beats are allowed.
- DWRITE:
  - stall=1 for one cycle; cacheMemWen=1; cacheDin=fill register.
  - Next state is PREQ if PREFETCH_EN, with the prefetch address = fillBlockAddr+1 (mod 2^BADDR; all-ones wraps to 0). Otherwise next state is IDLE.
  - The pipeline's retry in the next cycle hits.
- PREQ/PBEAT: same memory handshake as DREQ/DBEAT, with fillBlockAddr = the prefetch address.
  - stall=miss, so hits continue without stalling.
  - After the last beat: pbData=assembled block, pbTag=prefetch address, pbValid=1, go to IDLE. No cache write is made.
  - A miss during a prefetch stalls until the prefetch completes. IDLE then services the miss, including a buffer hit if the miss is for the prefetched line.
- Latency, hit: 0 stall cycles.
- Latency, stream-buffer hit: 2 stall cycles (IDLE miss, DWRITE).
- Latency, memory miss: 1 (IDLE) + request cycles up to and including ack + BEATS beat cycles (+ gaps) + 1 (DWRITE).
- Only one outstanding memory transaction at any time.
- The stream buffer is never written to the cache except on a matching miss. A new prefetch overwrites it.
- Beat counter width is max(1, log2(BEATS)). The counter wraps to 0 after the last beat.
- ren deasserted mid-refill: the refill completes and writes the cache; stall follows the rules above.

Test Plan:
- Reset asserted mid-DBEAT (beat 1 of 4) -> next cycle stall=0, memRen=0, cacheMemWen=0; a later late memBeatValid produces no cache write.
- BLOCK_WORDS=4, BEAT_WORDS=1, PREFETCH_EN=0; miss at addr 0x100, ack after 2 cycles, beats 0xA0..0xA3 with one gap -> one cacheMemWen cycle with fillBlockAddr=0x10 and cacheDin={A3,A2,A1,A0}; stall deasserts the following cycle; dout=0xA2 for addr 0x108.
- PREFETCH_EN=1; miss at 0x100 -> after DWRITE, memRen with fillBlockAddr=0x11 and stall=0 while ren hits continue; then a miss at 0x110 -> stall exactly 2 cycles, memRen stays 0, and cacheDin = the prefetched block.
- Miss at 0x200 while a prefetch of 0x11 is in PBEAT -> stall held until the prefetch ends, then DREQ for 0x20; pbValid stays 1 for 0x11.
- BEAT_WORDS=2: a 2-beat refill places beat0 in the low 64 bits; fill at block address all-ones -> prefetch address 0.
- Miss with memReqAck held low for 10 cycles -> memRen stays 1 and beats ignored throughout; beat capture starts only after ack.

Source files
------------

// File: rtl/icache_refill_controller.sv
// Instruction-cache miss controller: multi-beat block refill from memory
// plus an optional one-entry next-line stream buffer.
module icache_refill_controller #(
    parameter int ADDR_SIZE   = 32,
    parameter int WORD_BITS   = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int BEAT_WORDS  = 1,
    parameter int PREFETCH_EN = 1,
    localparam int BLOCK_BITS = BLOCK_WORDS * WORD_BITS,
    localparam int BEAT_BITS  = BEAT_WORDS * WORD_BITS,
    localparam int OFF        = $clog2(BLOCK_WORDS * WORD_BITS / 8),
    localparam int BADDR      = ADDR_SIZE - OFF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ren,
    input  logic [ADDR_SIZE-1:0]  addr,
    output logic                  stall,
    output logic [WORD_BITS-1:0]  dout,
    output logic [BADDR-1:0]      lookupBlockAddr,
    output logic                  cacheRen,
    input  logic                  cacheHit,
    input  logic [BLOCK_BITS-1:0] cacheDout,
    output logic                  cacheMemWen,
    output logic [BADDR-1:0]      fillBlockAddr,
    output logic [BLOCK_BITS-1:0] cacheDin,
    output logic                  memRen,
    input  logic                  memReqAck,
    input  logic                  memBeatValid,
    input  logic [BEAT_BITS-1:0]  memBeatData
);

    localparam int BEATS = BLOCK_WORDS / BEAT_WORDS;
    localparam int WOFF  = $clog2(WORD_BITS / 8);
    localparam int WIDX  = OFF - WOFF;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {
        IDLE, DREQ, DBEAT, DWRITE, PREQ, PBEAT
    } state_t;

    state_t state, state_n;

    logic [CW-1:0]         cnt;
    logic [BLOCK_BITS-1:0] fill;
    logic [BLOCK_BITS-1:0] fill_beat;
    logic [BLOCK_BITS-1:0] pb_data;
    logic [BADDR-1:0]      fill_addr;
    logic [BADDR-1:0]      pb_tag;
    logic                  pb_valid;
    logic                  miss;
    logic                  pb_hit;
    logic                  beat_we;
    logic                  last_beat;
    logic [WIDX-1:0]       widx;
    logic                  unused_bits;

    assign lookupBlockAddr = addr[ADDR_SIZE-1:OFF];
    assign widx            = addr[OFF-1:WOFF];
    assign dout            = cacheDout[widx*WORD_BITS +: WORD_BITS];
    assign unused_bits     = |(addr & ADDR_SIZE'((1 << WOFF) - 1));

    assign cacheRen      = ren && !reset;
    assign miss          = cacheRen && !cacheHit;
    assign pb_hit        = pb_valid && (pb_tag == lookupBlockAddr);
    assign fillBlockAddr = fill_addr;
    assign last_beat     = (cnt == CW'(BEATS - 1));
    assign beat_we       = memBeatValid && (state == DBEAT || state == PBEAT);

    always_comb begin
        fill_beat = fill;
        fill_beat[cnt*BEAT_BITS +: BEAT_BITS] = memBeatData;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        stall       = 1'b0;
        memRen      = 1'b0;
        cacheMemWen = 1'b0;
        cacheDin    = '0;
        unique case (state)
            IDLE: begin
                stall = miss;
                if (miss) state_n = pb_hit ? DWRITE : DREQ;
            end
            DREQ: begin
                stall  = 1'b1;
                memRen = 1'b1;
                if (memReqAck) state_n = DBEAT;
            end
            DBEAT: begin
                stall = 1'b1;
                if (memBeatValid && last_beat) state_n = DWRITE;
            end
            DWRITE: begin
                stall       = 1'b1;
                cacheMemWen = 1'b1;
                cacheDin    = fill;
                state_n     = (PREFETCH_EN != 0) ? PREQ : IDLE;
            end
            PREQ: begin
                stall  = miss;
                memRen = 1'b1;
                if (memReqAck) state_n = PBEAT;
            end
            PBEAT: begin
                stall = miss;
                if (memBeatValid && last_beat) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Fill register, beat counter, stream buffer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            fill      <= '0;
            fill_addr <= '0;
            pb_valid  <= 1'b0;
            pb_tag    <= '0;
            pb_data   <= '0;
        end else begin
            if (state == IDLE && miss) begin
                fill_addr <= lookupBlockAddr;
                if (pb_hit) begin
                    fill     <= pb_data;
                    pb_valid <= 1'b0;
                end
            end
            if ((state == DREQ || state == PREQ) && memReqAck) begin
                cnt <= '0;
            end
            if (beat_we) begin
                fill <= fill_beat;
                cnt  <= last_beat ? '0 : cnt + CW'(1);
            end
            if (state == DWRITE && PREFETCH_EN != 0) begin
                fill_addr <= fill_addr + BADDR'(1);
            end
            if (state == PBEAT && memBeatValid && last_beat) begin
                pb_data  <= fill_beat;
                pb_tag   <= fill_addr;
                pb_valid <= 1'b1;
            end
        end
    end

endmodule
